keypad_scan_fifo: RTL and testbench

- Parametrised successor to the fixed 4x3 keypad entry path. Scans an N_ROWS x N_COLS matrix and debounces over whole sweeps. Accepted key codes are buffered in a first-word-fall-through FIFO with a rd_en/dav handshake.
- Sits in the input stage. It feeds the datapath/FSM and the LCD path, so keystrokes are not lost while the consumer is busy.

---
 rtl/keypad_scan_fifo.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Row-scanned keypad with whole-sweep debounce feeding a first-word-fall-through
// key-code FIFO (rd_en/dav handshake). All outputs are registered.
module keypad_scan_fifo #(
    parameter int N_ROWS     = 4,
    parameter int N_COLS     = 3,
    parameter int CODE_W     = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_COLS-1:0]           col,
    output logic [N_ROWS-1:0]           row,
    input  logic                        rd_en,
    output logic [CODE_W-1:0]           key_code,
    output logic                        dav,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        key_held,
    output logic                        overflow
);

    localparam int RIDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int SCNT_W = $clog2(SCAN_DIV);
    localparam int DCNT_W = $clog2(DEBOUNCE + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [SCNT_W-1:0] SCAN_LAST  = SCNT_W'(SCAN_DIV - 1);
    localparam logic [RIDX_W-1:0] ROW_LAST   = RIDX_W'(N_ROWS - 1);
    localparam logic [DCNT_W-1:0] DEB_LAST   = DCNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam bit                DEB_SINGLE = (DEBOUNCE == 32'd1);

    typedef enum logic [1:0] {
        NOKEY     = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Number of set bits, saturated at 2 (only "none", "one", "many" matter)
    function automatic logic [1:0] count_sat(input logic [N_COLS-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int c = 0; c < N_COLS; c++) begin
            n = (v[c] && (n != 2'd2)) ? n + 2'd1 : n;
        end
        return n;
    endfunction

    function automatic logic [CODE_W-1:0] col_index(input logic [N_COLS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int c = N_COLS - 1; c >= 0; c--) begin
            idx = v[c] ? CODE_W'(c) : idx;
        end
        return idx;
    endfunction

    // Scan state
    logic [SCNT_W-1:0] scan_cnt_r;
    logic [RIDX_W-1:0] row_idx_r;
    logic [N_ROWS-1:0] row_r;
    logic              row_end_s;
    logic              sweep_end_s;

    // Sweep accumulation
    logic [1:0]        keys_acc_r;
    logic [CODE_W-1:0] code_acc_r;
    logic [1:0]        row_keys_s;
    logic [CODE_W-1:0] row_code_s;
    logic [1:0]        keys_sum_s;
    logic [CODE_W-1:0] res_code_s;
    logic              res_valid_s;

    // Debounce FSM
    state_t            state_r;
    logic [DCNT_W-1:0] deb_cnt_r;
    logic [CODE_W-1:0] stored_r;
    logic              key_held_r;
    logic              res_match_s;
    logic              cnt_done_s;
    logic              push_s;

    // FIFO
    logic [CODE_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              dav_r;
    logic [CODE_W-1:0] key_code_r;
    logic              overflow_r;
    logic              pop_s;
    logic              full_s;
    logic              wr_s;
    logic              drop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  remain_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CODE_W-1:0] head_nxt_s;

    // Window boundaries and the combined result of the sweep ending this cycle
    always_comb begin
        row_end_s   = (scan_cnt_r == SCAN_LAST);
        sweep_end_s = row_end_s && (row_idx_r == ROW_LAST);
        row_keys_s  = count_sat(col);
        row_code_s  = CODE_W'(int'(row_idx_r) * N_COLS) + col_index(col);
        keys_sum_s  = ((keys_acc_r == 2'd2) || (row_keys_s == 2'd2)) ? 2'd2
                                                                      : keys_acc_r + row_keys_s;
        res_code_s  = (keys_acc_r == 2'd1) ? code_acc_r : row_code_s;
        res_valid_s = sweep_end_s && (keys_sum_s == 2'd1);
        res_match_s = res_valid_s && (res_code_s == stored_r);
        cnt_done_s  = (deb_cnt_r == DEB_LAST);
    end

    // Row window timer and one-hot row drive
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_r <= '0;
            row_idx_r  <= '0;
            row_r      <= N_ROWS'(1'b1);
        end else if (row_end_s) begin
            scan_cnt_r <= '0;
            if (sweep_end_s) begin
                row_idx_r <= '0;
                row_r     <= N_ROWS'(1'b1);
            end else begin
                row_idx_r <= row_idx_r + RIDX_W'(1'b1);
                row_r     <= row_r << 1;
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SCNT_W'(1'b1);
        end
    end

    // Per-sweep key tally; restarts after every sweep end
    always_ff @(posedge clock) begin
        if (reset || sweep_end_s) begin
            keys_acc_r <= 2'd0;
            code_acc_r <= '0;
        end else if (row_end_s) begin
            keys_acc_r <= keys_sum_s;
            code_acc_r <= res_code_s;
        end
    end

    // Push decision is taken on the sweep-end cycle so the code is visible next cycle
    always_comb begin
        push_s = 1'b0;
        if (sweep_end_s) begin
            case (state_r)
                NOKEY:     push_s = res_valid_s && DEB_SINGLE;
                DEB_PRESS: push_s = res_match_s && cnt_done_s;
                default:   push_s = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Debounce FSM, stepped once per sweep
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= NOKEY;
            deb_cnt_r  <= '0;
            stored_r   <= '0;
            key_held_r <= 1'b0;
        end else if (sweep_end_s) begin
            case (state_r)
                NOKEY: begin
                    if (res_valid_s) begin
                        stored_r <= res_code_s;
                        if (DEB_SINGLE) begin
                            state_r    <= HELD;
                            key_held_r <= 1'b1;
                        end else begin
                            state_r   <= DEB_PRESS;
                            deb_cnt_r <= DCNT_W'(1'b1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (res_match_s) begin
                        if (cnt_done_s) begin
                            state_r    <= HELD;
                            key_held_r <= 1'b1;
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DCNT_W'(1'b1);
                        end
                    end else if (res_valid_s) begin
                        stored_r  <= res_code_s;
                        deb_cnt_r <= DCNT_W'(1'b1);
                    end else begin
                        state_r <= NOKEY;
                    end
                end
                HELD: begin
                    if (!res_match_s) begin
                        if (DEB_SINGLE) begin
                            state_r    <= NOKEY;
                            key_held_r <= 1'b0;
                        end else begin
                            state_r   <= DEB_REL;
                            deb_cnt_r <= DCNT_W'(1'b1);
                        end
                    end
                end
                DEB_REL: begin
                    if (res_match_s) begin
                        state_r <= HELD;
                    end else if (cnt_done_s) begin
                        state_r    <= NOKEY;
                        key_held_r <= 1'b0;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DCNT_W'(1'b1);
                    end
                end
                default: begin
                    state_r    <= NOKEY;
                    deb_cnt_r  <= '0;
                    key_held_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO next-state; the head register is preloaded so it shows the new head one cycle later
    always_comb begin
        pop_s        = rd_en && dav_r;
        full_s       = (count_r == FIFO_FULL);
        wr_s         = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        count_nxt_s  = count_r + CNT_W'(wr_s) - CNT_W'(pop_s);
        remain_s     = count_r - CNT_W'(pop_s);
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
        if (remain_s != '0) begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end else if (wr_s) begin
            head_nxt_s = res_code_s;
        end else begin
            head_nxt_s = key_code_r;
        end
    end

    // Storage array, cleared on reset so stale codes never resurface
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= res_code_s;
        end
    end

    // FIFO pointers, occupancy and registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            dav_r      <= 1'b0;
            key_code_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + PTR_W'(wr_s);
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            dav_r      <= (count_nxt_s != '0);
            key_code_r <= head_nxt_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign row        = row_r;
    assign key_code   = key_code_r;
    assign dav        = dav_r;
    assign fifo_count = count_r;
    assign key_held   = key_held_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo: directed scenarios plus random key
// traffic compared against a sweep-level reference model with a queue FIFO.
module tb_keypad_scan_fifo;

    localparam int NR    = 4;
    localparam int NC    = 3;
    localparam int CW    = 4;
    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int FD    = 4;
    localparam int SWEEP = NR * SD;

    logic          clock = 1'b0;
    logic          reset;
    logic [NC-1:0] col;
    logic [NR-1:0] row;
    logic          rd_en;
    logic [CW-1:0] key_code;
    logic          dav;
    logic [2:0]    fifo_count;
    logic          key_held;
    logic          overflow;

    logic [NC-1:0] kmat [NR];

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_cyc;
    int m_state;
    int m_cnt;
    int m_stored;
    int m_q[$];
    bit m_over;
    int m_code;

    keypad_scan_fifo #(
        .N_ROWS(NR), .N_COLS(NC), .CODE_W(CW),
        .SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .col(col), .row(row), .rd_en(rd_en),
        .key_code(key_code), .dav(dav), .fifo_count(fifo_count),
        .key_held(key_held), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // physical keypad: a pressed key connects its row line to its column line
    always_comb begin
        col = '0;
        for (int r = 0; r < NR; r++) begin
            col = col | (row[r] ? kmat[r] : '0);
        end
    end

    function automatic int sweep_result();
        int n;
        int code;
        n = 0;
        code = -1;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (kmat[r][c]) begin
                    n++;
                    code = r * NC + c;
                end
            end
        end
        return (n == 1) ? code : -1;
    endfunction

    function automatic void model_edge();
        bit pop;
        bit push;
        int res;
        if (reset) begin
            m_cyc = 0; m_state = 0; m_cnt = 0; m_stored = 0;
            m_q.delete(); m_over = 0; m_code = 0;
            return;
        end
        pop  = rd_en && (m_q.size() != 0);
        push = 0;
        if (m_cyc == SWEEP - 1) begin
            res = sweep_result();
            case (m_state)
                0: if (res >= 0) begin
                       m_stored = res;
                       if (DB == 1) begin push = 1; m_state = 2; end
                       else begin m_cnt = 1; m_state = 1; end
                   end
                1: if (res == m_stored) begin
                       m_cnt++;
                       if (m_cnt == DB) begin push = 1; m_state = 2; end
                   end else if (res >= 0) begin
                       m_stored = res; m_cnt = 1;
                   end else begin
                       m_state = 0;
                   end
                2: if (res != m_stored) begin
                       if (DB == 1) m_state = 0;
                       else begin m_cnt = 1; m_state = 3; end
                   end
                3: if (res == m_stored) m_state = 2;
                   else begin
                       m_cnt++;
                       if (m_cnt == DB) m_state = 0;
                   end
                default: m_state = 0;
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(m_stored);
            else m_over = 1;
        end
        if (m_q.size() != 0) m_code = m_q[0];
        m_cyc = (m_cyc + 1) % SWEEP;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < NR; r++) kmat[r] = '0;
    endtask

    task automatic set_key(input int code);
        clear_keys();
        kmat[code / NC] = 3'b001 << (code % NC);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd_en = 1'b0;
        clear_keys();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press_release(input int code);
        set_key(code);
        ticks(3 * SWEEP);
        clear_keys();
        ticks(3 * SWEEP);
    endtask

    task automatic pop_once();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (row !== 4'b0001) begin bad++; $display("FAIL reset_row got=%b want=0001", row); end
        total++; if (dav !== 1'b0) begin bad++; $display("FAIL reset_dav got=%b want=0", dav); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", key_code); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", key_held); end
    endtask

    task automatic test_scan();
        logic [NR-1:0] exp_row;
        do_reset();
        for (int i = 0; i < 4 * SWEEP; i++) begin
            tick();
            exp_row = 4'b0001 << (((i + 1) / SD) % NR);
            total++; if (row !== exp_row) begin bad++; $display("FAIL scan_row cyc=%0d got=%b want=%b", i, row, exp_row); end
            total++; if ({dav, fifo_count, overflow} !== 5'b0) begin
                bad++; $display("FAIL scan_idle cyc=%0d dav=%b count=%0d ovf=%b want all 0", i, dav, fifo_count, overflow);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_key(7);
        ticks(2 * SWEEP - 1);
        total++; if (dav !== 1'b0) begin bad++; $display("FAIL hold_early_dav got=%b want=0", dav); end
        tick();
        total++; if (dav !== 1'b1) begin bad++; $display("FAIL hold_dav got=%b want=1", dav); end
        total++; if (key_code !== 4'd7) begin bad++; $display("FAIL hold_code got=%0d want=7", key_code); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL hold_held got=%b want=1", key_held); end
        ticks(2 * SWEEP);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL hold_norepeat got=%0d want=1", fifo_count); end
        clear_keys();
        ticks(SWEEP);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL hold_debrel got=%b want=1", key_held); end
        ticks(SWEEP);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", key_held); end
        total++; if (key_code !== 4'd7 || dav !== 1'b1) begin
            bad++; $display("FAIL hold_keep code=%0d dav=%b want 7/1", key_code, dav);
        end
    endtask

    task automatic test_bounce();
        bit pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            if (pattern[s]) set_key(7); else clear_keys();
            for (int i = 0; i < SWEEP; i++) begin
                tick();
                total++; if (dav !== 1'b0 || fifo_count !== 3'd0) begin
                    bad++; $display("FAIL bounce sweep=%0d cyc=%0d dav=%b count=%0d want 0/0", s, i, dav, fifo_count);
                end
            end
        end
    endtask

    task automatic test_order();
        int codes [3] = '{1, 5, 9};
        do_reset();
        for (int k = 0; k < 3; k++) press_release(codes[k]);
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL order_count got=%0d want=3", fifo_count); end
        for (int k = 0; k < 3; k++) begin
            total++; if (dav !== 1'b1 || key_code !== CW'(codes[k])) begin
                bad++; $display("FAIL order_pop%0d dav=%b code=%0d want 1/%0d", k, dav, key_code, codes[k]);
            end
            pop_once();
        end
        total++; if (dav !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL order_empty dav=%b count=%0d want 0/0", dav, fifo_count);
        end
        total++; if (key_code !== 4'd9) begin bad++; $display("FAIL order_hold code=%0d want=9", key_code); end
        // rd_en on an empty FIFO is ignored
        pop_once();
        total++; if (fifo_count !== 3'd0 || dav !== 1'b0) begin
            bad++; $display("FAIL order_emptypop count=%0d dav=%b want 0/0", fifo_count, dav);
        end
    endtask

    task automatic test_overflow();
        int codes [5] = '{0, 2, 4, 6, 8};
        int exp_out [4] = '{2, 4, 6, 10};
        do_reset();
        for (int k = 0; k < 4; k++) press_release(codes[k]);
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_full count=%0d ovf=%b want 4/0", fifo_count, overflow);
        end
        press_release(codes[4]);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (key_code !== 4'd0) begin bad++; $display("FAIL ovf_head got=%0d want=0", key_code); end
        // push of code 10 lands on the same edge as a pop while full
        set_key(10);
        ticks(2 * SWEEP - 1);
        pop_once();
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_pushpop_count got=%0d want=4", fifo_count); end
        clear_keys();
        for (int k = 0; k < 4; k++) begin
            total++; if (key_code !== CW'(exp_out[k])) begin
                bad++; $display("FAIL ovf_drain%0d got=%0d want=%0d", k, key_code, exp_out[k]);
            end
            pop_once();
        end
        total++; if (dav !== 1'b0 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_end dav=%b ovf=%b want 0/1", dav, overflow);
        end
        do_reset();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_ghost_reset();
        do_reset();
        kmat[0] = 3'b001;
        kmat[2] = 3'b100;
        ticks(3 * SWEEP);
        total++; if (dav !== 1'b0 || key_held !== 1'b0) begin
            bad++; $display("FAIL ghost dav=%b held=%b want 0/0", dav, key_held);
        end
        set_key(3);
        ticks(2 * SWEEP);
        total++; if (dav !== 1'b1 || key_code !== 4'd3) begin
            bad++; $display("FAIL ghost_pre dav=%b code=%0d want 1/3", dav, key_code);
        end
        clear_keys();
        ticks(2 * SWEEP);
        set_key(4);
        ticks(SWEEP + 5);
        reset = 1'b1;
        tick();
        total++; if (row !== 4'b0001 || dav !== 1'b0 || fifo_count !== 3'd0 || key_code !== 4'd0
                     || key_held !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL midreset row=%b dav=%b count=%0d code=%0d held=%b ovf=%b", row, dav, fifo_count, key_code, key_held, overflow);
        end
        reset = 1'b0;
        ticks(SWEEP);
        total++; if (dav !== 1'b0) begin bad++; $display("FAIL midreset_fresh dav=%b want=0", dav); end
        ticks(SWEEP);
        total++; if (dav !== 1'b1 || key_code !== 4'd4) begin
            bad++; $display("FAIL midreset_push dav=%b code=%0d want 1/4", dav, key_code);
        end
    endtask

    task automatic test_random();
        int hold_left;
        int sel;
        logic [NR-1:0] exp_row;
        do_reset();
        hold_left = 0;
        for (int s = 0; s < 80; s++) begin
            if (hold_left == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) clear_keys();
                else if (sel < 9) set_key($urandom_range(0, NR * NC - 1));
                else begin
                    set_key($urandom_range(0, NR * NC - 1));
                    sel = $urandom_range(0, NR * NC - 1);
                    kmat[sel / NC] = kmat[sel / NC] | (3'b001 << (sel % NC));
                end
                hold_left = $urandom_range(1, 4);
            end
            hold_left--;
            for (int i = 0; i < SWEEP; i++) begin
                rd_en = ($urandom_range(0, 5) == 0);
                tick();
                exp_row = 4'b0001 << (m_cyc / SD);
                total++; if (row !== exp_row) begin bad++; $display("FAIL rnd_row s=%0d got=%b want=%b", s, row, exp_row); end
                total++; if (fifo_count !== 3'(m_q.size()) || dav !== (m_q.size() != 0)) begin
                    bad++; $display("FAIL rnd_fifo s=%0d count=%0d dav=%b want=%0d", s, fifo_count, dav, m_q.size());
                end
                total++; if (key_code !== CW'(m_code)) begin bad++; $display("FAIL rnd_code s=%0d got=%0d want=%0d", s, key_code, m_code); end
                total++; if (key_held !== (m_state >= 2)) begin bad++; $display("FAIL rnd_held s=%0d got=%b want=%0d", s, key_held, m_state >= 2); end
                total++; if (overflow !== m_over) begin bad++; $display("FAIL rnd_ovf s=%0d got=%b want=%b", s, overflow, m_over); end
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_en = 1'b0;
        clear_keys();
        test_reset();
        test_scan();
        test_hold();
        test_bounce();
        test_order();
        test_overflow();
        test_ghost_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
